// File: rtl/ov7670_capture.sv
// rtl/ov7670_capture.sv - OV7670 parallel-bus pixel capture with decimation and output FIFO
// Camera signals are oversampled in GLOBAL_CLK; pixels leave through a first-word-fall-through FIFO.
module ov7670_capture #(
   parameter int DATA_WIDTH      = 8,
   parameter int BYTES_PER_PIXEL = 2,
   parameter int FRAME_WIDTH     = 640,
   parameter int FRAME_HEIGHT    = 480,
   parameter int DECIM_LOG2      = 0,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                                  GLOBAL_CLK,
   input  logic                                  RESET,
   input  logic                                  ENABLE,
   input  logic                                  CONFIG_FINISHED,
   input  logic [DATA_WIDTH-1:0]                 PIXEL,
   input  logic                                  VSYNC,
   input  logic                                  HREF,
   input  logic                                  PCLK,
   output logic [DATA_WIDTH*BYTES_PER_PIXEL-1:0] PIX_DATA,
   output logic [$clog2(FRAME_WIDTH)-1:0]        PIX_X,
   output logic [$clog2(FRAME_HEIGHT)-1:0]       PIX_Y,
   output logic                                  PIX_SOF,
   output logic                                  PIX_EOL,
   output logic                                  PIX_VALID,
   input  logic                                  PIX_READY,
   output logic                                  FRAME_DONE,
   output logic                                  OVERFLOW
);
   localparam int PW = DATA_WIDTH * BYTES_PER_PIXEL;
   localparam int XW = $clog2(FRAME_WIDTH);
   localparam int YW = $clog2(FRAME_HEIGHT);
   localparam int CW = $clog2(FRAME_WIDTH + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = PW + XW + YW + 2;

   localparam logic [1:0] WAIT_CFG = 2'd0;
   localparam logic [1:0] WAIT_VS  = 2'd1;
   localparam logic [1:0] ACTIVE   = 2'd2;

   localparam logic [CW-1:0] COL_END = CW'(FRAME_WIDTH);
   localparam logic [CW-1:0] COL_EOL = CW'(FRAME_WIDTH - (1 << DECIM_LOG2));
   localparam logic [CW-1:0] CMASK   = CW'((1 << DECIM_LOG2) - 1);
   localparam logic [YW-1:0] RMASK   = YW'((1 << DECIM_LOG2) - 1);
   localparam logic [YW-1:0] ROW_MAX = YW'(FRAME_HEIGHT - 1);
   localparam logic [AW:0]   FULL    = (AW+1)'(FIFO_DEPTH);

   logic [2:0]            pclk_sr, vs_sr, href_sr;
   logic [DATA_WIDTH-1:0] pix_d1, pix_d2;
   logic                  pclk_rise, vs_rise, vs_fall, href_s, href_rise, href_fall;

   // PIXEL rides the same two-stage delay as PCLK so pix_d2 is the byte latched by the edge.
   always_ff @(posedge GLOBAL_CLK) begin
      if (RESET) begin
         pclk_sr <= '0;
         vs_sr   <= '0;
         href_sr <= '0;
         pix_d1  <= '0;
         pix_d2  <= '0;
      end else begin
         pclk_sr <= {pclk_sr[1:0], PCLK};
         vs_sr   <= {vs_sr[1:0], VSYNC};
         href_sr <= {href_sr[1:0], HREF};
         pix_d1  <= PIXEL;
         pix_d2  <= pix_d1;
      end
   end

   assign pclk_rise = pclk_sr[1] & ~pclk_sr[2];
   assign vs_rise   = vs_sr[1] & ~vs_sr[2];
   assign vs_fall   = ~vs_sr[1] & vs_sr[2];
   assign href_s    = href_sr[1];
   assign href_rise = href_sr[1] & ~href_sr[2];
   assign href_fall = ~href_sr[1] & href_sr[2];

   logic [1:0]            state;
   logic                  phase;
   logic [DATA_WIDTH-1:0] hi_byte;
   logic [CW-1:0]         col;
   logic [YW-1:0]         row;
   logic                  st_valid;
   logic [EW-1:0]         st_entry;
   logic                  frame_done_r, overflow_r;
   logic [EW-1:0]         mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [AW:0]           count;

   logic          eff_phase, capture, complete, in_line, keep, push, pop;
   logic [CW-1:0] eff_col;
   logic [EW-1:0] new_entry;

   // A byte arriving together with the HREF rise already belongs to the new line.
   always_comb begin
      eff_phase = href_rise ? 1'b0 : phase;
      eff_col   = href_rise ? '0 : col;
      capture   = (state == ACTIVE) && pclk_rise && href_s;
      complete  = capture && ((BYTES_PER_PIXEL == 1) || eff_phase);
      in_line   = eff_col != COL_END;
      keep      = complete && in_line && ((eff_col & CMASK) == '0) && ((row & RMASK) == '0);
      new_entry = {PW'({hi_byte, pix_d2}), XW'(eff_col >> DECIM_LOG2), YW'(row >> DECIM_LOG2),
                   (eff_col == '0) && (row == '0), eff_col == COL_EOL};
      pop       = PIX_VALID && PIX_READY;
      push      = st_valid && ((count != FULL) || pop);
   end

   always_ff @(posedge GLOBAL_CLK) begin
      if (RESET || !ENABLE) begin
         state        <= WAIT_CFG;
         phase        <= 1'b0;
         hi_byte      <= '0;
         col          <= '0;
         row          <= '0;
         st_valid     <= 1'b0;
         st_entry     <= '0;
         frame_done_r <= 1'b0;
         overflow_r   <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
      end else begin
         frame_done_r <= 1'b0;
         case (state)
            WAIT_CFG: if (CONFIG_FINISHED) state <= WAIT_VS;
            WAIT_VS:  if (vs_fall) state <= ACTIVE;
            ACTIVE:   if (vs_rise) begin
               state        <= WAIT_VS;
               frame_done_r <= 1'b1;
            end
            default:  state <= WAIT_CFG;
         endcase

         if (vs_fall) begin
            col <= '0;
            row <= '0;
         end else if (state == ACTIVE) begin
            if (href_rise) begin
               col   <= '0;
               phase <= 1'b0;
            end
            if (href_fall) begin
               phase <= 1'b0;
               if (row != ROW_MAX) row <= row + 1'b1;
            end
            if (capture) begin
               if ((BYTES_PER_PIXEL == 2) && !eff_phase) begin
                  hi_byte <= pix_d2;
                  phase   <= 1'b1;
               end else begin
                  phase <= 1'b0;
                  if (in_line) col <= eff_col + 1'b1;
               end
            end
         end

         st_valid <= keep;
         st_entry <= new_entry;

         // A write into a full FIFO only lands when the same cycle frees a slot.
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         else if (st_valid) overflow_r <= 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge GLOBAL_CLK)
      if (push) mem[wr_ptr] <= st_entry;

   assign PIX_VALID  = count != '0;
   assign {PIX_DATA, PIX_X, PIX_Y, PIX_SOF, PIX_EOL} = PIX_VALID ? mem[rd_ptr] : '0;
   assign FRAME_DONE = frame_done_r;
   assign OVERFLOW   = overflow_r;
endmodule

// File: tb/tb_ov7670_capture.sv
// tb/tb_ov7670_capture.sv - randomized bench for ov7670_capture against a frame-level pixel model
// Three instances share the camera bus: 2x2 RGB565, 4x4 with 2x decimation, 8x4 with backpressure.
module tb_ov7670_capture;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, cfg, vsync, href, pclk;
   logic [7:0] pixel;
   logic       en_a, en_d, en_b, rdy_a, rdy_d, rdy_b, rand_rdy;

   logic [15:0] a_data, d_data, b_data;
   logic [0:0]  a_x, a_y;
   logic [1:0]  d_x, d_y, b_y;
   logic [2:0]  b_x;
   logic a_sof, a_eol, a_vld, a_fd, a_ovf;
   logic d_sof, d_eol, d_vld, d_fd, d_ovf;
   logic b_sof, b_eol, b_vld, b_fd, b_ovf;

   ov7670_capture #(.FRAME_WIDTH(2), .FRAME_HEIGHT(2), .DECIM_LOG2(0), .FIFO_DEPTH(4)) u_a (
      .GLOBAL_CLK(clk), .RESET(rst), .ENABLE(en_a), .CONFIG_FINISHED(cfg), .PIXEL(pixel),
      .VSYNC(vsync), .HREF(href), .PCLK(pclk), .PIX_DATA(a_data), .PIX_X(a_x), .PIX_Y(a_y),
      .PIX_SOF(a_sof), .PIX_EOL(a_eol), .PIX_VALID(a_vld), .PIX_READY(rdy_a),
      .FRAME_DONE(a_fd), .OVERFLOW(a_ovf));

   ov7670_capture #(.FRAME_WIDTH(4), .FRAME_HEIGHT(4), .DECIM_LOG2(1), .FIFO_DEPTH(4)) u_d (
      .GLOBAL_CLK(clk), .RESET(rst), .ENABLE(en_d), .CONFIG_FINISHED(cfg), .PIXEL(pixel),
      .VSYNC(vsync), .HREF(href), .PCLK(pclk), .PIX_DATA(d_data), .PIX_X(d_x), .PIX_Y(d_y),
      .PIX_SOF(d_sof), .PIX_EOL(d_eol), .PIX_VALID(d_vld), .PIX_READY(rdy_d),
      .FRAME_DONE(d_fd), .OVERFLOW(d_ovf));

   ov7670_capture #(.FRAME_WIDTH(8), .FRAME_HEIGHT(4), .DECIM_LOG2(0), .FIFO_DEPTH(4)) u_b (
      .GLOBAL_CLK(clk), .RESET(rst), .ENABLE(en_b), .CONFIG_FINISHED(cfg), .PIXEL(pixel),
      .VSYNC(vsync), .HREF(href), .PCLK(pclk), .PIX_DATA(b_data), .PIX_X(b_x), .PIX_Y(b_y),
      .PIX_SOF(b_sof), .PIX_EOL(b_eol), .PIX_VALID(b_vld), .PIX_READY(rdy_b),
      .FRAME_DONE(b_fd), .OVERFLOW(b_ovf));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, want, $time);
      end
   endtask

   function automatic logic [31:0] pk(input logic sof, input logic eol, input logic [5:0] y,
                                      input logic [7:0] x, input logic [15:0] d);
      return {sof, eol, y, x, d};
   endfunction

   logic [31:0] obs [3];
   logic        vld [3], rdy [3], fd [3];
   assign obs[0] = pk(a_sof, a_eol, 6'(a_y), 8'(a_x), a_data);
   assign obs[1] = pk(d_sof, d_eol, 6'(d_y), 8'(d_x), d_data);
   assign obs[2] = pk(b_sof, b_eol, 6'(b_y), 8'(b_x), b_data);
   assign vld = '{a_vld, d_vld, b_vld};
   assign rdy = '{rdy_a, rdy_d, rdy_b};
   assign fd  = '{a_fd, d_fd, b_fd};

   // Frame geometry of each instance, used only by the reference model.
   int pw [3] = '{2, 4, 8};
   int ph [3] = '{2, 4, 4};
   int pd [3] = '{0, 1, 0};

   logic [31:0] q0 [$], q1 [$], q2 [$];
   int exp_n [3] = '{0, 0, 0};
   int exp_fd [3] = '{0, 0, 0};
   int seen [3] = '{0, 0, 0};
   int fd_pulses [3] = '{0, 0, 0};
   int fd_cycles [3] = '{0, 0, 0};
   logic fd_prev [3] = '{1'b0, 1'b0, 1'b0};
   logic hold_pend [3] = '{1'b0, 1'b0, 1'b0};
   logic [31:0] hold_val [3];

   logic [7:0] lb [64];
   int nb_cur;
   int limit = 1000;

   task automatic qpush(input int k, input logic [31:0] v);
      exp_n[k]++;
      case (k)
         0: q0.push_back(v);
         1: q1.push_back(v);
         default: q2.push_back(v);
      endcase
   endtask

   function automatic int qsize(input int k);
      return (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
   endfunction

   function automatic logic [31:0] qpop(input int k);
      if (k == 0) return q0.pop_front();
      if (k == 1) return q1.pop_front();
      return q2.pop_front();
   endfunction

   // Expected pixels of one camera line: byte pairs MSB-first, clipped to the frame width,
   // thinned by the decimation factor, at most 'limit' of them surviving a stalled FIFO.
   task automatic model_line(input int k, input int r);
      int f, row, n, kept;
      f    = 1 << pd[k];
      row  = (r < ph[k]) ? r : ph[k] - 1;
      n    = nb_cur / 2;
      kept = 0;
      for (int c = 0; c < n && c < pw[k]; c++) begin
         if (c % f == 0 && row % f == 0 && kept < limit) begin
            qpush(k, pk(c == 0 && row == 0, c == pw[k] - f, 6'(row / f), 8'(c / f),
                        {lb[2*c], lb[2*c+1]}));
            kept++;
         end
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (fd[k]) begin
            fd_cycles[k]++;
            if (!fd_prev[k]) fd_pulses[k]++;
         end
         fd_prev[k] = fd[k];
         if (vld[k] && hold_pend[k]) check_eq($sformatf("hold%0d", k), obs[k], hold_val[k]);
         hold_pend[k] = vld[k] && !rdy[k];
         hold_val[k]  = obs[k];
         if (vld[k] && rdy[k]) begin
            seen[k]++;
            if (qsize(k) > 0) check_eq($sformatf("pix%0d", k), obs[k], qpop(k));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int low = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) begin
            if (low >= 3 || $urandom_range(0, 2) != 0) begin
               rdy_b = 1'b1;
               low   = 0;
            end else begin
               rdy_b = 1'b0;
               low++;
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      pixel = b;
      pclk  = 1'b0;
      tick(2);
      pclk  = 1'b1;
      tick($urandom_range(1, 2));
   endtask

   task automatic disrupt(input int mode);
      if (mode == 2) begin
         rst = 1'b1;
         tick(1);
         rst = 1'b0;
      end else begin
         en_b = 1'b0;
         tick(1);
         en_b = 1'b1;
      end
      check_eq("cut_valid", b_vld, 0);
      check_eq("cut_ovf", b_ovf, 0);
      check_eq("cut_outputs", obs[2], 0);
      check_eq("cut_fd", b_fd, 0);
   endtask

   // mode 0 normal, 1 raise CONFIG_FINISHED after line 0, 2 reset / 3 disable after the first byte.
   task automatic run_frame(input int nlines, input int nb0, input int nb, input bit fixed,
                            input int mode);
      bit cap [3];
      cap[0] = en_a && cfg && (mode < 2);
      cap[1] = en_d && cfg && (mode < 2);
      cap[2] = en_b && cfg && (mode < 2);
      vsync = 1'b0;
      tick(6);
      for (int r = 0; r < nlines; r++) begin
         nb_cur = (r == 0) ? nb0 : nb;
         for (int i = 0; i < nb_cur; i++) lb[i] = fixed ? 8'(8'h12 + 34 * i) : 8'($urandom);
         for (int k = 0; k < 3; k++) if (cap[k]) model_line(k, r);
         href = 1'b1;
         for (int i = 0; i < nb_cur; i++) begin
            send_byte(lb[i]);
            if (r == 0 && i == 0 && mode >= 2) disrupt(mode);
         end
         pclk = 1'b0;
         href = 1'b0;
         tick(4);
         if (mode == 1 && r == 0) cfg = 1'b1;
      end
      tick(4);
      vsync = 1'b1;
      tick(10);
      for (int k = 0; k < 3; k++) if (cap[k]) exp_fd[k]++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; cfg = 1'b0; vsync = 1'b1; href = 1'b0; pclk = 1'b0; pixel = 8'h00;
      en_a = 1'b1; en_d = 1'b1; en_b = 1'b1;
      rdy_a = 1'b1; rdy_d = 1'b1; rdy_b = 1'b1; rand_rdy = 1'b0;
      tick(3);
      check_eq("rst_valid", a_vld, 0);
      check_eq("rst_sof", a_sof, 0);
      check_eq("rst_eol", a_eol, 0);
      check_eq("rst_fd", a_fd, 0);
      check_eq("rst_ovf", a_ovf, 0);
      check_eq("rst_data", a_data, 0);
      check_eq("rst_x", a_x, 0);
      check_eq("rst_y", a_y, 0);
      rst = 1'b0;
      tick(4);

      run_frame(2, 4, 4, 0, 0);
      run_frame(2, 4, 4, 0, 1);
      check_eq("gated", seen[0] + seen[1] + seen[2], 0);

      en_d = 1'b0; en_b = 1'b0;
      tick(2);
      run_frame(2, 4, 4, 1, 0);
      run_frame(2, 4, 4, 0, 0);

      en_a = 1'b0; en_d = 1'b1;
      tick(2);
      run_frame(4, 8, 8, 0, 0);
      run_frame(4, 8, 8, 0, 0);

      en_d = 1'b0; en_b = 1'b1; rand_rdy = 1'b1;
      tick(2);
      run_frame(4, 20, 17, 0, 0);
      for (int f = 0; f < 3; f++)
         run_frame(4, $urandom_range(2, 21), $urandom_range(2, 21), 0, 0);
      rand_rdy = 1'b0; rdy_b = 1'b1;
      tick(2);
      run_frame(2, 5, 4, 0, 0);

      rdy_b = 1'b0; limit = 4;
      run_frame(1, 12, 12, 0, 0);
      limit = 1000;
      check_eq("bp_ovf", b_ovf, 1);
      check_eq("bp_valid", b_vld, 1);
      rdy_b = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq($sformatf("drain%0d", i), b_vld, (i < 4) ? 1 : 0);
      end
      tick(1);
      check_eq("ovf_sticky", b_ovf, 1);
      en_b = 1'b0;
      tick(1);
      check_eq("ovf_clear", b_ovf, 0);
      en_b = 1'b1;
      tick(2);

      run_frame(2, 8, 8, 0, 2);
      run_frame(2, 8, 8, 0, 0);
      run_frame(2, 8, 8, 0, 3);
      run_frame(2, 8, 8, 0, 0);
      tick(10);

      for (int k = 0; k < 3; k++) begin
         check_eq($sformatf("count%0d", k), seen[k], exp_n[k]);
         check_eq($sformatf("fd_pulses%0d", k), fd_pulses[k], exp_fd[k]);
         check_eq($sformatf("fd_cycles%0d", k), fd_cycles[k], exp_fd[k]);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
